// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with double-buffered display value.
// Optional leading-zero blanking: define SEG7_LEAD_ZERO_BLANK_EN.
module seg7_scan_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DIV_WIDTH   = 16,
   parameter int HEX_MODE    = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic                    load_pending,
   output logic                    frame_done,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an_out
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam bit HEX = (HEX_MODE != 0);

   logic [DIV_WIDTH-1:0]    div_q;
   logic [IDX_W-1:0]        idx_q;
   logic [4*NUM_DIGITS-1:0] disp_q;
   logic [4*NUM_DIGITS-1:0] shad_q;
   logic [NUM_DIGITS-1:0]   ddp_q;
   logic [NUM_DIGITS-1:0]   sdp_q;
   logic                    pend_q;
   logic                    tick;
   logic                    boundary;
   logic [3:0]              nib;
   logic                    dp_sel;
   logic                    blank;
   logic [NUM_DIGITS-1:0]   an_n;

   function automatic logic [6:0] dec(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0: s = 7'b0000001;
         4'd1: s = 7'b1001111;
         4'd2: s = 7'b0010010;
         4'd3: s = 7'b0000110;
         4'd4: s = 7'b1001100;
         4'd5: s = 7'b0100100;
         4'd6: s = 7'b0100000;
         4'd7: s = 7'b0001111;
         4'd8: s = 7'b0000000;
         4'd9: s = 7'b0000100;
         default: begin
            s = 7'b1111111;
            if (HEX) begin
               case (v)
                  4'ha: s = 7'b0001000;
                  4'hb: s = 7'b1100000;
                  4'hc: s = 7'b0110001;
                  4'hd: s = 7'b1000010;
                  4'he: s = 7'b0110000;
                  4'hf: s = 7'b0111000;
                  default: s = 7'b1111111;
               endcase
            end
         end
      endcase
      return s;
   endfunction

   assign tick         = enable && (div_q == DIV_LAST);
   assign boundary     = tick && (idx_q == IDX_LAST);
   assign frame_done   = boundary;
   assign load_pending = pend_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         idx_q <= '0;
      end else if (!enable) begin
         div_q <= '0;
         idx_q <= '0;
      end else if (tick) begin
         div_q <= '0;
         idx_q <= boundary ? '0 : idx_q + IDX_W'(1);
      end else begin
         div_q <= div_q + DIV_WIDTH'(1);
      end
   end

   // Display only changes between frames, or at once while dark.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_q <= '0;
         shad_q <= '0;
         ddp_q  <= '0;
         sdp_q  <= '0;
         pend_q <= 1'b0;
      end else if (!enable || boundary) begin
         if (load) begin
            disp_q <= bcd_in;
            ddp_q  <= dp_in;
         end else if (pend_q) begin
            disp_q <= shad_q;
            ddp_q  <= sdp_q;
         end
         pend_q <= 1'b0;
      end else if (load) begin
         shad_q <= bcd_in;
         sdp_q  <= dp_in;
         pend_q <= 1'b1;
      end
   end

   always_comb begin
      nib    = 4'd0;
      dp_sel = 1'b0;
      an_n   = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib     = disp_q[4*i +: 4];
            dp_sel  = ddp_q[i];
            an_n[i] = 1'b0;
         end
      end
   end

`ifdef SEG7_LEAD_ZERO_BLANK_EN
   logic hi_nz;
   always_comb begin
      hi_nz = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((int'(idx_q) <= i) && (disp_q[4*i +: 4] != 4'd0))
            hi_nz = 1'b1;
      end
      blank = (idx_q != '0) && !hi_nz;
   end
`else
   assign blank = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_out <= 7'b1111111;
         dp_out  <= 1'b1;
         an_out  <= '1;
      end else if (!enable) begin
         seg_out <= 7'b1111111;
         dp_out  <= 1'b1;
         an_out  <= '1;
      end else begin
         seg_out <= blank ? 7'b1111111 : dec(nib);
         dp_out  <= ~dp_sel;
         an_out  <= an_n;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised bench for seg7_scan_driver against a frame-position model.
// Builds with or without SEG7_LEAD_ZERO_BLANK_EN.
module tb_seg7_scan_driver;

   localparam int N  = 4;
   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;

   logic        lp0, fd0, dp0, lp1, fd1, dp1;
   logic [6:0]  seg0, seg1;
   logic [3:0]  an0, an1;

   int tests = 0;
   int fails = 0;

   seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .DIV_WIDTH(4),
                      .HEX_MODE(0)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
      .bcd_in(bcd_in), .dp_in(dp_in), .load_pending(lp0),
      .frame_done(fd0), .seg_out(seg0), .dp_out(dp0), .an_out(an0));

   seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .DIV_WIDTH(4),
                      .HEX_MODE(1)) dut_hex (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
      .bcd_in(bcd_in), .dp_in(dp_in), .load_pending(lp1),
      .frame_done(fd1), .seg_out(seg1), .dp_out(dp1), .an_out(an1));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] v, input bit hex);
      case (v)
         4'd0: return 7'b0000001;
         4'd1: return 7'b1001111;
         4'd2: return 7'b0010010;
         4'd3: return 7'b0000110;
         4'd4: return 7'b1001100;
         4'd5: return 7'b0100100;
         4'd6: return 7'b0100000;
         4'd7: return 7'b0001111;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0000100;
         4'ha: return hex ? 7'b0001000 : 7'b1111111;
         4'hb: return hex ? 7'b1100000 : 7'b1111111;
         4'hc: return hex ? 7'b0110001 : 7'b1111111;
         4'hd: return hex ? 7'b1000010 : 7'b1111111;
         4'he: return hex ? 7'b0110000 : 7'b1111111;
         default: return hex ? 7'b0111000 : 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] shown(input logic [15:0] d, input int pos,
                                        input bit hex);
`ifdef SEG7_LEAD_ZERO_BLANK_EN
      int hi = 0;
      for (int i = 0; i < N; i++)
         if (d[4*i +: 4] != 4'd0) hi = i;
      if (pos > hi) return 7'b1111111;
`endif
      return ref_seg(d[4*pos +: 4], hex);
   endfunction

   // model: position within the frame plus the two buffers
   int          cnt;
   logic [15:0] m_disp, m_shad;
   logic [3:0]  m_ddp, m_sdp;
   bit          m_pend;
   logic [6:0]  e_seg, e_segh;
   logic        e_dp;
   logic [3:0]  e_an;
   bit          started = 0;

   always @(posedge clk or negedge rst_n) begin : model
      int pos;
      bit bnd;
      if (!rst_n) begin
         cnt = 0; m_disp = 0; m_shad = 0; m_ddp = 0; m_sdp = 0;
         m_pend = 0; e_seg = 7'h7f; e_segh = 7'h7f; e_dp = 1; e_an = 4'hf;
         started = 1;
      end else begin
         if (enable) begin
            pos    = cnt / RD;
            e_an   = ~(4'b0001 << pos);
            e_seg  = shown(m_disp, pos, 0);
            e_segh = shown(m_disp, pos, 1);
            e_dp   = ~m_ddp[pos];
         end else begin
            e_an = 4'hf; e_seg = 7'h7f; e_segh = 7'h7f; e_dp = 1;
         end
         bnd = enable && (cnt == N*RD-1);
         if (!enable || bnd) begin
            cnt = 0;
            if (load) begin
               m_disp = bcd_in; m_ddp = dp_in;
            end else if (m_pend) begin
               m_disp = m_shad; m_ddp = m_sdp;
            end
            m_pend = 0;
         end else begin
            cnt++;
            if (load) begin
               m_shad = bcd_in; m_sdp = dp_in; m_pend = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("an", an0, e_an);
         chk("seg", seg0, e_seg);
         chk("seg_hex", seg1, e_segh);
         chk("dp", dp0, e_dp);
         chk("pending", lp0, m_pend);
         chk("frame_done", fd0, enable && rst_n && (cnt == N*RD-1));
         chk("an_hex", an1, e_an);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_fd_neg();
      bit hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         if (fd0) hit = 1;
      end
      if (!hit) chk("fd_timeout", 0, 1);
   endtask

   task automatic wait_fd_pos();
      bit hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(posedge clk);
         #1;
         if (fd0) hit = 1;
      end
      if (!hit) chk("fd_timeout", 0, 1);
   endtask

   initial begin
      int pulses;
      logic [15:0] mask;
      rst_n = 1; enable = 0; load = 0; bcd_in = 0; dp_in = 0;
      #2 rst_n = 0;
      cyc(2);
      @(negedge clk);
      chk("rst_seg", seg0, 7'b1111111);
      chk("rst_an", an0, 4'b1111);
      chk("rst_pend", lp0, 0);
      cyc(1);
      rst_n = 1;

      // direct load while dark, then scan 1234
      load = 1; bcd_in = 16'h1234; dp_in = 4'b0001;
      cyc(1);
      load = 0; enable = 1;
      @(negedge clk);
      chk("dark_an", an0, 4'b1111);
      @(negedge clk);
      chk("d0_seg", seg0, 7'b1001100);
      chk("d0_an", an0, 4'b1110);
      chk("d0_dp", dp0, 0);
      repeat (4) @(negedge clk);
      chk("d1_seg", seg0, 7'b0000110);
      chk("d1_an", an0, 4'b1101);
      chk("d1_dp", dp0, 1);

      // shadow load mid-frame, then overwrite
      cyc(1);
      load = 1; bcd_in = 16'h5678; dp_in = 4'b0010;
      cyc(1);
      load = 0;
      @(negedge clk);
      chk("pend_set", lp0, 1);
      cyc(2);
      load = 1; bcd_in = 16'h4321; dp_in = 4'b0100;
      cyc(1);
      load = 0;
      wait_fd_neg();
      @(negedge clk);
      @(negedge clk);
      chk("newframe_seg", seg0, 7'b1001111);
      chk("newframe_an", an0, 4'b1110);
      chk("newframe_pend", lp0, 0);

      // load on the boundary cycle
      wait_fd_pos();
      load = 1; bcd_in = 16'h2468; dp_in = 4'b1000;
      cyc(1);
      load = 0;
      @(negedge clk);
      chk("coll_pend", lp0, 0);
      @(negedge clk);
      chk("coll_seg", seg0, 7'b0000000);

      // hex nibble on digit 0
      cyc(1);
      enable = 0; load = 1; bcd_in = 16'h123A; dp_in = 4'b0000;
      cyc(1);
      load = 0; enable = 1;
      @(negedge clk);
      @(negedge clk);
      chk("hexA_blank", seg0, 7'b1111111);
      chk("hexA_hex", seg1, 7'b0001000);

      // drop enable on digit 2, then re-enable
      repeat (8) @(negedge clk);
      chk("d2_an", an0, 4'b1011);
      cyc(1);
      enable = 0;
      @(negedge clk);
      @(negedge clk);
      chk("off_an", an0, 4'b1111);
      chk("off_seg", seg0, 7'b1111111);
      cyc(2);
      enable = 1;
      @(negedge clk);
      repeat (4) begin
         @(negedge clk);
         chk("reen_d0", an0, 4'b1110);
      end
      @(negedge clk);
      chk("reen_d1", an0, 4'b1101);

      // frame_done period
      pulses = 0;
      repeat (48) begin
         @(negedge clk);
         if (fd0) pulses++;
      end
      chk("fd_count", pulses, 3);

      // reset mid-scan with a pending value
      cyc(1);
      load = 1; bcd_in = 16'h1111;
      cyc(1);
      load = 0; rst_n = 0;
      #1;
      chk("mrst_seg", seg0, 7'b1111111);
      chk("mrst_an", an0, 4'b1111);
      chk("mrst_pend", lp0, 0);
      cyc(1);
      rst_n = 1;
      @(negedge clk);
      chk("mrst_hold", an0, 4'b1111);
      @(negedge clk);
      chk("mrst_d0_an", an0, 4'b1110);
      chk("mrst_d0_seg", seg0, 7'b0000001);

`ifdef SEG7_LEAD_ZERO_BLANK_EN
      cyc(1);
      enable = 0; load = 1; bcd_in = 16'h0050; dp_in = 4'b0000;
      cyc(1);
      load = 0; enable = 1;
      @(negedge clk);
      @(negedge clk);
      chk("lz_d0", seg0, 7'b0000001);
      repeat (4) @(negedge clk);
      chk("lz_d1", seg0, 7'b0100100);
      repeat (4) @(negedge clk);
      chk("lz_d2", seg0, 7'b1111111);
      repeat (4) @(negedge clk);
      chk("lz_d3", seg0, 7'b1111111);
`endif

      // random traffic
      cyc(1);
      for (int i = 0; i < 800; i++) begin
         rst_n  = ($urandom_range(0, 199) != 0);
         enable = ($urandom_range(0, 19) != 0);
         load   = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0: mask = 16'hffff;
            1: mask = 16'h00ff;
            2: mask = 16'h000f;
            default: mask = 16'h0000;
         endcase
         bcd_in = 16'($urandom) & mask;
         dp_in  = 4'($urandom);
         cyc(1);
      end
      rst_n = 1; enable = 0; load = 0;
      cyc(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
